// File: rtl/execute_mdu.sv
// Execute stage: operand forwarding, ALU, dest-reg select, plus an iterative MULT/DIV unit
// with HI/LO. Optional build macro MDU_EARLY_OUT_EN shortens multiplies whose multiplier runs out.
module execute_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         alu_ctrl,
  input  logic               alu_src,
  input  logic               reg_dst,
  input  logic               md_start,
  input  logic [1:0]         md_op,
  input  logic [WIDTH-1:0]   reg1,
  input  logic [WIDTH-1:0]   reg2,
  input  logic [RADDR_W-1:0] rs,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic [WIDTH-1:0]   sign_imm,
  input  logic [1:0]         forward_a,
  input  logic [1:0]         forward_b,
  input  logic [WIDTH-1:0]   fwd_mem_val,
  input  logic [WIDTH-1:0]   fwd_wb_val,
  output logic [RADDR_W-1:0] rs_haz,
  output logic [RADDR_W-1:0] rt_haz,
  output logic [WIDTH-1:0]   alu_out,
  output logic [WIDTH-1:0]   write_data,
  output logic [RADDR_W-1:0] write_reg,
  output logic               md_busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

`ifdef MDU_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} md_state_e;

  logic [WIDTH-1:0] srca, fwdb, srcb;
  logic [4:0]       shamt;

  always_comb begin
    case (forward_a)
      2'b01:   srca = fwd_mem_val;
      2'b10:   srca = fwd_wb_val;
      default: srca = reg1;
    endcase
    case (forward_b)
      2'b01:   fwdb = fwd_mem_val;
      2'b10:   fwdb = fwd_wb_val;
      default: fwdb = reg2;
    endcase
  end

  assign srcb       = alu_src ? sign_imm : fwdb;
  assign shamt      = 5'(sign_imm >> 6);
  assign rs_haz     = rs;
  assign rt_haz     = rt;
  assign write_data = fwdb;
  assign write_reg  = reg_dst ? rd : rt;

  logic [WIDTH-1:0] hi_q, lo_q;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      4'h0: alu_out = srca & srcb;
      4'h1: alu_out = srca | srcb;
      4'h2: alu_out = srca + srcb;
      4'h3: alu_out = srca ^ srcb;
      4'h4: alu_out = ~(srca | srcb);
      4'h6: alu_out = srca - srcb;
      4'h7: alu_out = {{(WIDTH-1){1'b0}}, $signed(srca) < $signed(srcb)};
      4'h8: alu_out = {{(WIDTH-1){1'b0}}, srca < srcb};
      4'h9: alu_out = srcb << shamt;
      4'hA: alu_out = srcb >> shamt;
      4'hB: alu_out = $signed(srcb) >>> shamt;
      4'hC: alu_out = hi_q;
      4'hD: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end

  // MDU state
  md_state_e          state_q;
  logic [1:0]         op_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q;    // mult: product; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand_q;  // mult: shifted multiplicand; div: divisor in low half
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   x_q;
  logic               neg_q, negrem_q, dz_q, busy_q;

  // Operand magnitudes at capture
  logic             cap_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign cap_sgn = ~md_op[0];
  assign a_neg   = cap_sgn & srca[WIDTH-1];
  assign b_neg   = cap_sgn & fwdb[WIDTH-1];
  assign a_mag   = a_neg ? -srca : srca;
  assign b_mag   = b_neg ? -fwdb : fwdb;

  // One radix-2 step
  logic [2*WIDTH-1:0] acc_mul, acc_div, mcand_nx;
  logic [WIDTH-1:0]   mplier_nx;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     trial;
  logic               run_last;

  always_comb begin
    acc_mul   = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mcand_nx  = mcand_q << 1;
    mplier_nx = mplier_q >> 1;
    div_sh    = {acc_q, 1'b0};
    trial     = div_sh[2*WIDTH:WIDTH] - {1'b0, mcand_q[WIDTH-1:0]};
    acc_div   = trial[WIDTH] ? div_sh[2*WIDTH-1:0]
                             : {trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    run_last  = (cnt_q == CntW'(WIDTH - 1)) ||
                (EarlyOut && !op_q[1] && (mplier_nx == '0));
  end

  // Sign fix-up and HI/LO values written on the FIX edge
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (dz_q) begin
        hi_fix = x_q;
        lo_fix = '1;
      end else begin
        lo_fix = neg_q    ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        hi_fix = negrem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      x_q      <= '0;
      neg_q    <= 1'b0;
      negrem_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_start) begin
            op_q     <= md_op;
            cnt_q    <= '0;
            x_q      <= srca;
            neg_q    <= a_neg ^ b_neg;
            negrem_q <= a_neg;
            dz_q     <= md_op[1] & (fwdb == '0);
            busy_q   <= 1'b1;
            if (md_op[1]) begin
              acc_q    <= {{WIDTH{1'b0}}, a_mag};
              mcand_q  <= {{WIDTH{1'b0}}, b_mag};
              mplier_q <= '0;
              state_q  <= (fwdb == '0) ? StFix : StRun;
            end else begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a_mag};
              mplier_q <= b_mag;
              state_q  <= StRun;
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q[1]) begin
            acc_q <= acc_div;
          end else begin
            acc_q    <= acc_mul;
            mcand_q  <= mcand_nx;
            mplier_q <= mplier_nx;
          end
          if (run_last) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign md_busy = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: ALU/forwarding vectors and MDU latency/result checks.
module tb_execute_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   alu_ctrl;
  logic         alu_src, reg_dst, md_start;
  logic [1:0]   md_op, forward_a, forward_b;
  logic [W-1:0] reg1, reg2, sign_imm, fwd_mem_val, fwd_wb_val;
  logic [4:0]   rs, rt, rd;
  logic [4:0]   rs_haz, rt_haz, write_reg;
  logic [W-1:0] alu_out, write_data, hi, lo;
  logic         md_busy;

  int total = 0;
  int bad   = 0;
  int n;
  int exp_lat;

  execute_mdu #(.WIDTH(W), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .reg_dst(reg_dst),
    .md_start(md_start), .md_op(md_op), .reg1(reg1), .reg2(reg2), .rs(rs), .rt(rt), .rd(rd),
    .sign_imm(sign_imm), .forward_a(forward_a), .forward_b(forward_b),
    .fwd_mem_val(fwd_mem_val), .fwd_wb_val(fwd_wb_val), .rs_haz(rs_haz), .rt_haz(rt_haz),
    .alu_out(alu_out), .write_data(write_data), .write_reg(write_reg), .md_busy(md_busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (md_busy === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; alu_ctrl = 4'h0; alu_src = 1'b0; reg_dst = 1'b0; md_start = 1'b0;
    md_op = 2'b00; forward_a = 2'b00; forward_b = 2'b00; reg1 = '0; reg2 = '0;
    sign_imm = '0; fwd_mem_val = '0; fwd_wb_val = '0; rs = '0; rt = '0; rd = '0;
    @(negedge clk);
    tick();
    tick();
    chk("reset_busy", W'(md_busy), 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    reset = 1'b0;

    // ALU and forwarding
    alu_ctrl = 4'h2; forward_a = 2'b10; fwd_wb_val = 32'd7; reg2 = 32'd5; reg1 = 32'd100;
    #1 chk("add_fwd_wb", alu_out, 32'd12);
    forward_a = 2'b11;
    #1 chk("add_fwd11_reg1", alu_out, 32'd105);
    forward_a = 2'b01; fwd_mem_val = 32'd20;
    #1 chk("add_fwd_mem", alu_out, 32'd25);
    forward_a = 2'b00; alu_ctrl = 4'h6; alu_src = 1'b1; sign_imm = 32'hFFFF_FFFF;
    #1 chk("sub_imm", alu_out, 32'd101);
    alu_src = 1'b0; reg1 = 32'hFFFF_FFFF; reg2 = 32'd1; alu_ctrl = 4'h7;
    #1 chk("slt_signed", alu_out, 32'd1);
    alu_ctrl = 4'h8;
    #1 chk("sltu", alu_out, 32'd0);
    alu_ctrl = 4'h4; reg1 = 32'h0; reg2 = 32'hF0F0_F0F0;
    #1 chk("nor", alu_out, 32'h0F0F_0F0F);
    alu_ctrl = 4'h5;
    #1 chk("undef_op", alu_out, 32'h0);
    reg_dst = 1'b1; rd = 5'd7; rt = 5'd3; rs = 5'd9;
    #1 chk("write_reg_rd", W'(write_reg), 32'd7);
    reg_dst = 1'b0;
    #1 chk("write_reg_rt", W'(write_reg), 32'd3);
    chk("rs_haz", W'(rs_haz), 32'd9);
    forward_b = 2'b10; fwd_wb_val = 32'hDEAD_BEEF;
    #1 chk("write_data_fwd", write_data, 32'hDEAD_BEEF);
    forward_b = 2'b00;

    // MULT -3 * 5 with an ignored start while busy
    reg1 = 32'hFFFF_FFFD; reg2 = 32'd5; md_op = 2'b00; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    chk("mult_busy_start", W'(md_busy), 32'h1);
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 3) begin
        alu_ctrl = 4'hD;
        #1 chk("mflo_during_busy", alu_out, 32'h0);
      end
      md_start = (n == 5);
      if (n == 5) begin md_op = 2'b11; reg1 = 32'd100; reg2 = 32'd7; end
      tick();
    end
    md_start = 1'b0;
    chk("mult_latency", n, 32'd33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    alu_ctrl = 4'hC;
    #1 chk("mfhi", alu_out, 32'hFFFF_FFFF);

    // DIV -7 / 2 via forwarded SrcA; immediate must not be used
    forward_a = 2'b01; fwd_mem_val = 32'hFFFF_FFF9; reg1 = 32'd1234; reg2 = 32'd2;
    alu_src = 1'b1; sign_imm = 32'd9; md_op = 2'b10; md_start = 1'b1;
    tick();
    md_start = 1'b0; forward_a = 2'b00; alu_src = 1'b0;
    count_busy(n);
    chk("div_latency", n, 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU by zero
    reg1 = 32'd9; reg2 = 32'd0; md_op = 2'b11; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    count_busy(n);
    chk("divz_latency", n, 32'd1);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_hi", hi, 32'h0000_0009);

    // Signed overflow divide
    reg1 = 32'h8000_0000; reg2 = 32'hFFFF_FFFF; md_op = 2'b10; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    count_busy(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // Reset aborts a MULTU in flight
    reg1 = 32'd3; reg2 = 32'hFFFF_0000; md_op = 2'b01; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    n = 0;
    while (md_busy === 1'b1 && n < 200) begin
      n++;
      if (n == 10) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        break;
      end
      tick();
    end
    chk("abort_reached", n, 32'd10);
    chk("abort_busy", W'(md_busy), 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);

    // Reset wins over a simultaneous start
    reset = 1'b1; md_start = 1'b1; md_op = 2'b01;
    tick();
    reset = 1'b0; md_start = 1'b0;
    chk("rst_start_busy", W'(md_busy), 32'h0);
    tick();
    chk("rst_start_busy2", W'(md_busy), 32'h0);

    // MULTU 3 * 2: latency depends on the early-out build
`ifdef MDU_EARLY_OUT_EN
    exp_lat = 3;
`else
    exp_lat = 33;
`endif
    reg1 = 32'd3; reg2 = 32'd2; md_op = 2'b01; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    count_busy(n);
    chk("multu_latency", n, W'(exp_lat));
    chk("multu_lo", lo, 32'd6);
    chk("multu_hi", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
